// File: rtl/cv32e41p_div_multibit.sv
// cv32e41p_div_multibit: iterative restoring divider/remainder, BITS_PER_CYCLE quotient bits per clock,
// with single-cycle divide-by-zero and signed-overflow results.
module cv32e41p_div_multibit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             Clk_CI,
   input  logic             Rst_RBI,
   input  logic [WIDTH-1:0] OpA_DI,
   input  logic [WIDTH-1:0] OpB_DI,
   input  logic [1:0]       OpCode_SI,
   input  logic             InVld_SI,
   output logic             InRdy_SO,
   input  logic             Kill_SI,
   output logic             OutVld_SO,
   input  logic             OutRdy_SI,
   output logic [WIDTH-1:0] Res_DO,
   output logic             DivZero_SO,
   output logic             Ovf_SO
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  r_q, r_d, q_q, q_d, b_q, b_d;
   logic              rem_q, rem_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, ovf_q, ovf_d;
   logic              a_neg, b_neg, dz, ovf, qb;
   logic [WIDTH-1:0]  a_abs, b_abs, r_s, q_s;
   logic [WIDTH:0]    t;

   assign a_neg = OpCode_SI[0] & OpA_DI[WIDTH-1];
   assign b_neg = OpCode_SI[0] & OpB_DI[WIDTH-1];
   assign a_abs = a_neg ? -OpA_DI : OpA_DI;
   assign b_abs = b_neg ? -OpB_DI : OpB_DI;
   assign dz    = OpB_DI == '0;
   assign ovf   = OpCode_SI[0] & (OpA_DI == MIN) & (&OpB_DI);

   // Chained restoring sub-steps; R stays below |B| so it fits WIDTH bits between steps.
   always_comb begin
      r_s = r_q;
      q_s = q_q;
      t   = '0;
      qb  = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         t   = {r_s, q_s[WIDTH-1]};
         qb  = t >= {1'b0, b_q};
         r_s = qb ? WIDTH'(t - {1'b0, b_q}) : t[WIDTH-1:0];
         q_s = {q_s[WIDTH-2:0], qb};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      b_d     = b_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      if (Kill_SI) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (InVld_SI) begin
               // Special cases preload the final result and skip sign fix.
               state_d = (dz | ovf) ? FINISH : DIVIDE;
               cnt_d   = CW'(N - 1);
               r_d     = dz ? OpA_DI : '0;
               q_d     = dz ? '1 : ovf ? MIN : a_abs;
               b_d     = b_abs;
               rem_d   = OpCode_SI[1];
               negq_d  = (a_neg ^ b_neg) & ~dz & ~ovf;
               negr_d  = a_neg & ~dz & ~ovf;
               dz_d    = dz;
               ovf_d   = ovf;
            end
            DIVIDE: begin
               r_d     = r_s;
               q_d     = q_s;
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == '0) ? FINISH : DIVIDE;
            end
            FINISH:  state_d = OutRdy_SI ? IDLE : FINISH;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         rem_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign InRdy_SO   = state_q == IDLE;
   assign OutVld_SO  = state_q == FINISH;
   assign Res_DO     = rem_q ? (negr_q ? -r_q : r_q) : (negq_q ? -q_q : q_q);
   assign DivZero_SO = OutVld_SO & dz_q;
   assign Ovf_SO     = OutVld_SO & ovf_q;
endmodule

// File: tb/tb_cv32e41p_div_multibit.sv
// tb_cv32e41p_div_multibit: scoreboard bench driving a 1-bit/cycle and a 4-bit/cycle divider
// against an arithmetic reference model.
module tb_cv32e41p_div_multibit;
   localparam logic [31:0] MIN = 32'h8000_0000;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] opa[2], opb[2], res[2];
   logic [1:0]  opc[2];
   logic        inv[2], inr[2], kill[2], ovld[2], ordy[2], dzf[2], ovf[2];
   int          total = 0, bad = 0, cyc = 0;
   bit          seen[2];

   typedef struct {logic [31:0] res; logic dz; logic ov; int acc; int lat;} exp_t;
   exp_t q0[$], q1[$];

   always @(posedge clk) cyc <= cyc + 1;

   cv32e41p_div_multibit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_k1 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .OpA_DI(opa[0]), .OpB_DI(opb[0]), .OpCode_SI(opc[0]),
      .InVld_SI(inv[0]), .InRdy_SO(inr[0]), .Kill_SI(kill[0]), .OutVld_SO(ovld[0]),
      .OutRdy_SI(ordy[0]), .Res_DO(res[0]), .DivZero_SO(dzf[0]), .Ovf_SO(ovf[0]));

   cv32e41p_div_multibit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_k4 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .OpA_DI(opa[1]), .OpB_DI(opb[1]), .OpCode_SI(opc[1]),
      .InVld_SI(inv[1]), .InRdy_SO(inr[1]), .Kill_SI(kill[1]), .OutVld_SO(ovld[1]),
      .OutRdy_SI(ordy[1]), .Res_DO(res[1]), .DivZero_SO(dzf[1]), .Ovf_SO(ovf[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference: RISC-V division semantics straight from 64-bit arithmetic.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input int u);
      exp_t   e;
      longint sa, sb;
      e.dz = 1'b0; e.ov = 1'b0; e.acc = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         e.dz = 1'b1; e.res = op[1] ? a : 32'hFFFF_FFFF;
      end else if (op[0] && a == MIN && b == 32'hFFFF_FFFF) begin
         e.ov = 1'b1; e.res = op[1] ? 32'd0 : MIN;
      end else if (op[0]) e.res = 32'(op[1] ? sa % sb : sa / sb);
      else e.res = op[1] ? a % b : a / b;
      e.lat = (e.dz || e.ov) ? 1 : (u == 0 ? 33 : 9);
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accept.
   task automatic issue(input int u, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input bit rnd);
      exp_t e;
      e = model(a, b, op, u);
      opa[u] = a; opb[u] = b; opc[u] = op; inv[u] = 1'b1;
      for (int n = 0; n < 300 && !(inr[u] && !kill[u]); n++) begin
         @(negedge clk);
         if (rnd) ordy[u] = $urandom_range(0, 2) != 0;
      end
      if (!(inr[u] && !kill[u])) chk("accept_timeout", 0, 1);
      else begin
         e.acc = cyc;
         if (u == 0) q0.push_back(e); else q1.push_back(e);
         @(negedge clk);
      end
      inv[u] = 1'b0;
   endtask

   task automatic wait_vld(input int u);
      for (int n = 0; n < 100 && !ovld[u]; n++) @(negedge clk);
      chk("vld_timeout", 32'(ovld[u]), 1);
   endtask

   task automatic drain();
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      for (int n = 0; n < 500 && (q0.size() + q1.size()) != 0; n++) @(negedge clk);
      chk("drain", q0.size() + q1.size(), 0);
   endtask

   task automatic chk_rst(input int u);
      chk("rst_inrdy", 32'(inr[u]), 1);
      chk("rst_outvld", 32'(ovld[u]), 0);
      chk("rst_res", res[u], 0);
      chk("rst_dz", 32'(dzf[u]), 0);
      chk("rst_ovf", 32'(ovf[u]), 0);
   endtask

   task automatic mon(input int u);
      exp_t e;
      int   sz;
      sz = (u == 0) ? q0.size() : q1.size();
      if (!rst_n) seen[u] = 1'b0;
      else if (ovld[u]) begin
         if (sz == 0) chk("unexpected_result", 32'(ovld[u]), 0);
         else begin
            e = (u == 0) ? q0[0] : q1[0];
            if (!seen[u]) begin
               chk("latency", cyc - e.acc, e.lat);
               chk("divzero", 32'(dzf[u]), 32'(e.dz));
               chk("ovf", 32'(ovf[u]), 32'(e.ov));
            end
            chk("res", res[u], e.res);
            seen[u] = 1'b1;
            if (ordy[u] || kill[u]) begin
               if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               seen[u] = 1'b0;
            end
         end
      end else begin
         seen[u] = 1'b0;
         chk("flags_idle", {30'd0, dzf[u], ovf[u]}, 0);
      end
   endtask

   always @(negedge clk) begin
      #2;
      for (int u = 0; u < 2; u++) mon(u);
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return MIN;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      for (int u = 0; u < 2; u++) begin
         opa[u] = '0; opb[u] = '0; opc[u] = '0; inv[u] = 1'b0; kill[u] = 1'b0; ordy[u] = 1'b1;
      end
      repeat (3) @(negedge clk);
      chk_rst(0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_rst(0); chk_rst(1);
      // Basic, signed and special-case operations on both unit widths
      issue(0, 100, 7, 0, 0);
      issue(0, 100, 7, 2, 0);
      issue(1, -32'sd7, 2, 1, 0);
      issue(1, -32'sd7, 2, 3, 0);
      issue(1, 7, -32'sd2, 1, 0);
      issue(0, -32'sd7, 2, 3, 0);
      issue(0, 5, 0, 0, 0);
      issue(0, 5, 0, 3, 0);
      issue(1, 5, 0, 2, 0);
      issue(1, MIN, 32'hFFFF_FFFF, 1, 0);
      issue(1, MIN, 32'hFFFF_FFFF, 3, 0);
      issue(1, MIN, 32'hFFFF_FFFF, 0, 0);
      issue(0, MIN, 32'hFFFF_FFFF, 1, 0);
      issue(0, MIN, 1, 1, 0);
      drain();
      // Back-pressure with a pending request
      ordy[0] = 1'b0;
      issue(0, 1000, 33, 0, 0);
      wait_vld(0);
      opa[0] = 77; opb[0] = 5; opc[0] = 2; inv[0] = 1'b1;
      repeat (10) begin
         chk("bp_inrdy", 32'(inr[0]), 0);
         chk("bp_outvld", 32'(ovld[0]), 1);
         @(negedge clk);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_vld", 32'(ovld[0]), 0);
      chk("bp_release_rdy", 32'(inr[0]), 1);
      issue(0, 77, 5, 2, 0);
      drain();
      // Kill in IDLE blocks the accept
      opa[1] = 9; opb[1] = 3; inv[1] = 1'b1; kill[1] = 1'b1;
      @(negedge clk);
      inv[1] = 1'b0; kill[1] = 1'b0;
      chk("kill_idle_rdy", 32'(inr[1]), 1);
      // Kill in DIVIDE cycle 5
      issue(0, 1000, 3, 0, 0);
      repeat (4) @(negedge clk);
      kill[0] = 1'b1;
      void'(q0.pop_back());
      @(negedge clk);
      kill[0] = 1'b0;
      chk("kill_div_rdy", 32'(inr[0]), 1);
      chk("kill_div_vld", 32'(ovld[0]), 0);
      repeat (40) @(negedge clk);
      // Kill in FINISH drops the result
      ordy[1] = 1'b0;
      issue(1, 9, 0, 2, 0);
      wait_vld(1);
      kill[1] = 1'b1;
      @(negedge clk);
      kill[1] = 1'b0; ordy[1] = 1'b1;
      chk("kill_fin_vld", 32'(ovld[1]), 0);
      chk("kill_fin_rdy", 32'(inr[1]), 1);
      // Randomized traffic with random back-pressure
      repeat (60) begin
         int u;
         u = $urandom_range(0, 1);
         issue(u, pick(), pick(), 2'($urandom_range(0, 3)), 1);
      end
      drain();
      // Asynchronous reset in the middle of a division
      issue(0, 12345, 17, 0, 0);
      repeat (3) @(negedge clk);
      void'(q0.pop_back());
      #1 rst_n = 1'b0;
      #1 chk_rst(0);
      chk_rst(1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("end_queues", q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
